// File: rtl/fwd_scoreboard_if.sv
// rtl/fwd_scoreboard_if.sv - issue/operand/forwarding bundle between the ID stage and the scoreboard
// The slave modport is the scoreboard side; the master modport is the ID control side.
interface fwd_scoreboard_if #(
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 5
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  logic                        issue_valid__i;
  logic                        issue_wen__i;
  logic [REG_AW-1:0]           issue_rd__i;
  logic [SEL_W-1:0]            issue_lat__i;
  logic [NUM_SRC*REG_AW-1:0]   src_rs__i;
  logic                        flush__i;
  logic [NUM_SRC*SEL_W-1:0]    fwd_sel__o;
  logic                        stall__o;
  logic                        busy__o;

  modport slave (
    input  issue_valid__i, issue_wen__i, issue_rd__i, issue_lat__i, src_rs__i, flush__i,
    output fwd_sel__o, stall__o, busy__o
  );

  modport master (
    output issue_valid__i, issue_wen__i, issue_rd__i, issue_lat__i, src_rs__i, flush__i,
    input  fwd_sel__o, stall__o, busy__o
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - forwarding select and hazard stall scoreboard for the ID stage
// Optional stall-cycle counter port stall_cnt__o enabled by macro FWD_SCB_STALL_CNT_EN.
module fwd_scoreboard #(
  parameter int NUM_SRC    = 2,
  parameter int PIPE_DEPTH = 3,
  parameter int REG_AW     = 5
) (
  input  logic clk__i,
  input  logic reset_n__i,
  fwd_scoreboard_if.slave sb_if
`ifdef FWD_SCB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt__o
`endif
);
  localparam int SEL_W = $clog2(PIPE_DEPTH + 1);

  // Index k holds pipeline stage k+1 (0 = EX for the 5-stage core).
  logic [PIPE_DEPTH-1:0] r_v;
  logic [PIPE_DEPTH-1:0] r_wen;
  logic [REG_AW-1:0]     r_rd  [PIPE_DEPTH];
  logic [SEL_W-1:0]      r_rem [PIPE_DEPTH];

  logic [SEL_W-1:0]         w_lat;
  logic [SEL_W-1:0]         w_issue_rem;
  logic [NUM_SRC-1:0]       w_hazard;
  logic [NUM_SRC*SEL_W-1:0] w_sel;
  logic                     w_stall;

  always_comb begin
    w_lat = sb_if.issue_lat__i;
    if (w_lat == '0) w_lat = SEL_W'(1);
    if (w_lat > SEL_W'(PIPE_DEPTH)) w_lat = SEL_W'(PIPE_DEPTH);
    w_issue_rem = w_lat - SEL_W'(1);
  end

  // Oldest-to-youngest scan so the youngest matching producer overrides.
  always_comb begin
    w_sel    = '0;
    w_hazard = '0;
    for (int j = 0; j < NUM_SRC; j++) begin
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
        if (r_v[k] && r_wen[k] && (sb_if.src_rs__i[j*REG_AW +: REG_AW] != '0) &&
            (r_rd[k] == sb_if.src_rs__i[j*REG_AW +: REG_AW])) begin
          if (r_rem[k] == '0) begin
            w_sel[j*SEL_W +: SEL_W] = SEL_W'(k + 1);
            w_hazard[j]             = 1'b0;
          end else begin
            w_sel[j*SEL_W +: SEL_W] = '0;
            w_hazard[j]             = 1'b1;
          end
        end
      end
    end
  end

  assign w_stall          = sb_if.issue_valid__i && (|w_hazard);
  assign sb_if.stall__o   = w_stall;
  assign sb_if.fwd_sel__o = w_sel;
  assign sb_if.busy__o    = |r_v;

  always_ff @(posedge clk__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      r_v   <= '0;
      r_wen <= '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
        r_rd[k]  <= '0;
        r_rem[k] <= '0;
      end
    end else if (sb_if.flush__i) begin
      r_v <= '0;
    end else begin
      r_v[0]   <= sb_if.issue_valid__i && !w_stall;
      r_wen[0] <= sb_if.issue_wen__i;
      r_rd[0]  <= sb_if.issue_rd__i;
      r_rem[0] <= w_issue_rem;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        r_v[k]   <= r_v[k-1];
        r_wen[k] <= r_wen[k-1];
        r_rd[k]  <= r_rd[k-1];
        r_rem[k] <= (r_rem[k-1] == '0) ? '0 : r_rem[k-1] - SEL_W'(1);
      end
    end
  end

`ifdef FWD_SCB_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk__i or negedge reset_n__i) begin
    if (!reset_n__i) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt__o = r_stall_cnt;
`endif
endmodule
